nms_window_core: RTL

Non-maximum suppression core for the Canny edge pipeline. It consumes the 3x3 window of packed {direction[1:0], gradient[23:0]} words produced by the NMS window shift-RAM stage, one window per pixel strobe. For each window it keeps the centre gradient only if it is a local maximum along the quantised gradient direction, and it forces border pixels to zero. The result is a raster stream of thinned magnitudes for the double-threshold / hysteresis stage.

---
 rtl/nms_window_core.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/nms_window_core.sv
// nms_window_core: non-maximum suppression over a 3x3 window of packed
// {direction[1:0], gradient} words. The centre gradient survives only when it
// is a local maximum along its quantised direction; border centres are zeroed.
// Optional feature macro: NMS_LOW_THRESH_EN adds a low_thresh input that zeroes
// kept, non-border maxima below the threshold (stage 2, no extra latency).
module nms_window_core #(
  parameter int WIDTH      = 636,
  parameter int DEPTH      = 508,
  parameter int GRAD_WIDTH = 24,
  parameter int DATA_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  data_en,
  input  logic                  matrix_clken,
  input  logic [DATA_WIDTH-1:0] matrix_p11,
  input  logic [DATA_WIDTH-1:0] matrix_p12,
  input  logic [DATA_WIDTH-1:0] matrix_p13,
  input  logic [DATA_WIDTH-1:0] matrix_p21,
  input  logic [DATA_WIDTH-1:0] matrix_p22,
  input  logic [DATA_WIDTH-1:0] matrix_p23,
  input  logic [DATA_WIDTH-1:0] matrix_p31,
  input  logic [DATA_WIDTH-1:0] matrix_p32,
  input  logic [DATA_WIDTH-1:0] matrix_p33,
`ifdef NMS_LOW_THRESH_EN
  input  logic [GRAD_WIDTH-1:0] low_thresh,
`endif
  output logic                  out_valid,
  output logic [GRAD_WIDTH-1:0] out_grad,
  output logic [1:0]            out_dir,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int COL_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [ROW_W-1:0]       cen_row;
  logic [COL_W-1:0]       cen_col;
  logic                   accept;
  logic                   last_win;
  logic                   border;
  logic [1:0]             dir_in;
  logic [GRAD_WIDTH-1:0]  g_c_in;
  logic [GRAD_WIDTH-1:0]  g_a_in;
  logic [GRAD_WIDTH-1:0]  g_b_in;

  logic                   v1;
  logic                   border1;
  logic                   last1;
  logic [1:0]             dir1;
  logic [GRAD_WIDTH-1:0]  g_c1;
  logic [GRAD_WIDTH-1:0]  g_a1;
  logic [GRAD_WIDTH-1:0]  g_b1;

  logic                   v2;
  logic                   last2;
  logic [1:0]             dir2;
  logic [GRAD_WIDTH-1:0]  res2;
  logic                   keep;

  // Neighbour direction codes carry no meaning for suppression.
  logic                   unused_dir_bits;

  assign dir_in   = matrix_p22[GRAD_WIDTH +: 2];
  assign g_c_in   = matrix_p22[GRAD_WIDTH-1:0];
  assign accept   = (state == RUN) && data_en && matrix_clken;
  assign last_win = (cen_row == ROW_LAST) && (cen_col == '0);
  assign border   = (cen_col == '0) || (cen_col == COL_LAST) || (cen_row == ROW_LAST);

  assign unused_dir_bits = ^{matrix_p11[DATA_WIDTH-1:GRAD_WIDTH], matrix_p12[DATA_WIDTH-1:GRAD_WIDTH],
                             matrix_p13[DATA_WIDTH-1:GRAD_WIDTH], matrix_p21[DATA_WIDTH-1:GRAD_WIDTH],
                             matrix_p23[DATA_WIDTH-1:GRAD_WIDTH], matrix_p31[DATA_WIDTH-1:GRAD_WIDTH],
                             matrix_p32[DATA_WIDTH-1:GRAD_WIDTH], matrix_p33[DATA_WIDTH-1:GRAD_WIDTH]};

  // Select the two neighbours lying along the centre's gradient direction.
  always_comb begin
    g_a_in = matrix_p21[GRAD_WIDTH-1:0];
    g_b_in = matrix_p23[GRAD_WIDTH-1:0];
    case (dir_in)
      2'b01: begin
        g_a_in = matrix_p13[GRAD_WIDTH-1:0];
        g_b_in = matrix_p31[GRAD_WIDTH-1:0];
      end
      2'b10: begin
        g_a_in = matrix_p12[GRAD_WIDTH-1:0];
        g_b_in = matrix_p32[GRAD_WIDTH-1:0];
      end
      2'b11: begin
        g_a_in = matrix_p11[GRAD_WIDTH-1:0];
        g_b_in = matrix_p33[GRAD_WIDTH-1:0];
      end
      default: begin
        g_a_in = matrix_p21[GRAD_WIDTH-1:0];
        g_b_in = matrix_p23[GRAD_WIDTH-1:0];
      end
    endcase
  end

  // Keep decision: strict against the earlier neighbour, non-strict against the later one.
  always_comb begin
    keep = (g_c1 > g_a1) && (g_c1 >= g_b1) && !border1;
`ifdef NMS_LOW_THRESH_EN
    if (g_c1 < low_thresh) keep = 1'b0;
`endif
  end

  // Frame FSM with centre-position counters and registered busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cen_row <= '0;
      cen_col <= '0;
      busy    <= 1'b0;
    end else if (!start) begin
      state   <= IDLE;
      cen_row <= '0;
      cen_col <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= RUN;
          cen_row <= ROW_W'(1);
          cen_col <= COL_W'(1);
          busy    <= 1'b1;
        end
        RUN: begin
          if (accept) begin
            if (last_win) state <= DRAIN;
            if (cen_col == COL_LAST) begin
              cen_col <= '0;
              cen_row <= cen_row + ROW_W'(1);
            end else begin
              cen_col <= cen_col + COL_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!v1 && !v2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline: operand capture, compare result, then output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_grad   <= '0;
      out_dir    <= '0;
    end else if (!start) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      v1         <= accept;
      v2         <= v1;
      out_valid  <= v2;
      frame_done <= v2 && last2;
      if (accept) begin
        g_c1    <= g_c_in;
        g_a1    <= g_a_in;
        g_b1    <= g_b_in;
        dir1    <= dir_in;
        border1 <= border;
        last1   <= last_win;
      end
      if (v1) begin
        res2  <= keep ? g_c1 : '0;
        dir2  <= dir1;
        last2 <= last1;
      end
      if (v2) begin
        out_grad <= res2;
        out_dir  <= dir2;
      end
    end
  end

endmodule
